// File: rtl/pc_npc_unit_pkg.sv
// rtl/pc_npc_unit_pkg.sv - shared encodings for the PC/nPC fetch-stage unit
// Contents: control-transfer encodings (cti_e) and FSM state codes (state_e).
package pc_npc_unit_pkg;

    typedef enum logic [1:0] {
        CTI_SEQ = 2'b00,
        CTI_BR  = 2'b01,
        CTI_JMP = 2'b10,
        CTI_RSV = 2'b11     // decoded as sequential
    } cti_e;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        ANNUL = 2'd2
    } state_e;

endpackage

// File: rtl/pc_npc_unit_if.sv
// rtl/pc_npc_unit_if.sv - control-unit / fetch-unit bundle for pc_npc_unit
// master: control side (drives stall/cti/taken/annul/disp/jmp_addr/trap/tbr, reads pc/npc/pc4/status)
// slave : pc_npc_unit side (opposite directions)
interface pc_npc_unit_if #(
    parameter int WIDTH = 32,
    parameter int ALIGN = 2
);
    import pc_npc_unit_pkg::*;

    logic                   stall_i;
    cti_e                   cti_i;
    logic                   taken_i;
    logic                   annul_i;
    logic [WIDTH-ALIGN-1:0] disp_i;
    logic [WIDTH-1:0]       jmp_addr_i;
    logic                   trap_i;
    logic [WIDTH-1:0]       tbr_i;
    logic [WIDTH-1:0]       pc_o;
    logic [WIDTH-1:0]       npc_o;
    logic [WIDTH-1:0]       pc4_o;
    logic                   fetch_valid_o;
    logic                   annulled_o;
    logic                   misalign_o;

    modport master (
        output stall_i, cti_i, taken_i, annul_i, disp_i, jmp_addr_i, trap_i, tbr_i,
        input  pc_o, npc_o, pc4_o, fetch_valid_o, annulled_o, misalign_o
    );

    modport slave (
        input  stall_i, cti_i, taken_i, annul_i, disp_i, jmp_addr_i, trap_i, tbr_i,
        output pc_o, npc_o, pc4_o, fetch_valid_o, annulled_o, misalign_o
    );

endinterface

// File: rtl/pc_npc_unit_pc_adder.sv
// rtl/pc_npc_unit_pc_adder.sv - combinational modulo-2^WIDTH address adder
// Ports: a, b (WIDTH) in; sum (WIDTH) out = a + b, carry-out discarded.
module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_npc_unit.sv
// rtl/pc_npc_unit.sv - SPARC-style PC/nPC register pair with next-pair selection
// Ports: clk, rst (sync active-high); bus (pc_npc_unit_if.slave) carrying the
// control inputs (stall, cti, taken, annul, disp, jmp_addr, trap, tbr) and the
// fetch outputs (pc, npc, pc4, fetch_valid, annulled, misalign).
module pc_npc_unit
    import pc_npc_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               ALIGN    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_npc_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0] STEP      = WIDTH'(1) << ALIGN;
    localparam logic [WIDTH-1:0] RESET_NPC = RESET_PC + STEP;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] npc_q;
    state_e           state_q;
    logic             fetch_valid_q;
    logic             annulled_q;
    logic             misalign_q;

    logic [WIDTH-1:0] npc_seq;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] tbr_next;
    logic             jmp_mis;
    logic             tbr_mis;

    // Word displacement sign-extended to WIDTH-ALIGN.. then scaled to bytes;
    // the low ALIGN bits of the result are always zero.
    assign br_off  = {{ALIGN{bus.disp_i[WIDTH-ALIGN-1]}}, bus.disp_i} << ALIGN;
    assign jmp_mis = |bus.jmp_addr_i[ALIGN-1:0];
    assign tbr_mis = |bus.tbr_i[ALIGN-1:0];

    pc_adder #(.WIDTH(WIDTH)) u_pc4      (.a(pc_q),      .b(STEP),   .sum(bus.pc4_o));
    pc_adder #(.WIDTH(WIDTH)) u_npc_seq  (.a(npc_q),     .b(STEP),   .sum(npc_seq));
    pc_adder #(.WIDTH(WIDTH)) u_br_tgt   (.a(pc_q),      .b(br_off), .sum(br_tgt));
    pc_adder #(.WIDTH(WIDTH)) u_trap_npc (.a(bus.tbr_i), .b(STEP),   .sum(tbr_next));

    assign bus.pc_o          = pc_q;
    assign bus.npc_o         = npc_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.annulled_o    = annulled_q;
    assign bus.misalign_o    = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            npc_q         <= RESET_NPC;
            state_q       <= BOOT;
            fetch_valid_q <= 1'b0;
            annulled_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    // Pair stays at the reset values for this one cycle.
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                    annulled_q    <= 1'b0;
                end
                default: begin
                    if (bus.trap_i) begin
                        // A misaligned vector leaves pc/npc/state untouched.
                        if (tbr_mis) begin
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q       <= bus.tbr_i;
                            npc_q      <= tbr_next;
                            state_q    <= RUN;
                            annulled_q <= 1'b0;
                        end
                    end else if (bus.stall_i) begin
                        // hold everything
                    end else if (state_q == ANNUL) begin
                        // Squashed delay-slot instruction: its control transfer is ignored.
                        pc_q       <= npc_q;
                        npc_q      <= npc_seq;
                        state_q    <= RUN;
                        annulled_q <= 1'b0;
                    end else begin
                        case (bus.cti_i)
                            CTI_BR: begin
                                pc_q <= npc_q;
                                if (bus.taken_i) begin
                                    npc_q <= br_tgt;
                                end else begin
                                    npc_q <= npc_seq;
                                    if (bus.annul_i) begin
                                        state_q    <= ANNUL;
                                        annulled_q <= 1'b1;
                                    end
                                end
                            end
                            CTI_JMP: begin
                                if (jmp_mis) begin
                                    misalign_q <= 1'b1;
                                end else begin
                                    pc_q  <= npc_q;
                                    npc_q <= bus.jmp_addr_i;
                                end
                            end
                            default: begin
                                pc_q  <= npc_q;
                                npc_q <= npc_seq;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_npc_unit.sv
// tb/tb_pc_npc_unit.sv - testbench for pc_npc_unit (32-bit/ALIGN 2 and 16-bit/ALIGN 1 instances)
module tb_pc_npc_unit;
    import pc_npc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, taken, annul, trap;
    logic [1:0]  cti;
    logic [31:0] disp, jmp, tbr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_npc_unit_if #(.WIDTH(32), .ALIGN(2)) bus_a ();
    pc_npc_unit_if #(.WIDTH(16), .ALIGN(1)) bus_b ();

    assign bus_a.stall_i    = stall;
    assign bus_a.cti_i      = cti_e'(cti);
    assign bus_a.taken_i    = taken;
    assign bus_a.annul_i    = annul;
    assign bus_a.disp_i     = disp[29:0];
    assign bus_a.jmp_addr_i = jmp;
    assign bus_a.trap_i     = trap;
    assign bus_a.tbr_i      = tbr;

    assign bus_b.stall_i    = stall;
    assign bus_b.cti_i      = cti_e'(cti);
    assign bus_b.taken_i    = taken;
    assign bus_b.annul_i    = annul;
    assign bus_b.disp_i     = disp[14:0];
    assign bus_b.jmp_addr_i = jmp[15:0];
    assign bus_b.trap_i     = trap;
    assign bus_b.tbr_i      = tbr[15:0];

    pc_npc_unit #(.WIDTH(32), .ALIGN(2), .RESET_PC(32'h0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pc_npc_unit #(.WIDTH(16), .ALIGN(1), .RESET_PC(16'h0100)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Reference model: index 0 = 32-bit unit, index 1 = 16-bit unit.
    int unsigned mw  [2] = '{32, 16};
    int unsigned mal [2] = '{2, 1};
    longint      mrp [2] = '{64'h0, 64'h100};
    longint      m_pc [2];
    longint      m_npc[2];
    bit          m_boot[2];
    bit          m_ann [2];
    bit          m_mis [2];

    task automatic model_step(input int k);
        longint mask, step, span, d, tgt, old_pc;
        mask = (longint'(1) << mw[k]) - 1;
        step = longint'(1) << mal[k];
        span = longint'(1) << (mw[k] - mal[k]);
        m_mis[k] = 1'b0;
        if (rst) begin
            m_pc[k]   = mrp[k];
            m_npc[k]  = (mrp[k] + step) & mask;
            m_boot[k] = 1'b1;
            m_ann[k]  = 1'b0;
        end else if (m_boot[k]) begin
            m_boot[k] = 1'b0;
        end else if (trap) begin
            tgt = longint'(tbr) & mask;
            if (tgt % step != 0) m_mis[k] = 1'b1;
            else begin
                m_pc[k]  = tgt;
                m_npc[k] = (tgt + step) & mask;
                m_ann[k] = 1'b0;
            end
        end else if (stall) begin
        end else if (m_ann[k]) begin
            m_pc[k]  = m_npc[k];
            m_npc[k] = (m_npc[k] + step) & mask;
            m_ann[k] = 1'b0;
        end else if (cti == 2'd1) begin
            old_pc  = m_pc[k];
            m_pc[k] = m_npc[k];
            if (taken) begin
                d = longint'(disp) & (span - 1);
                if (d >= span / 2) d = d - span;
                m_npc[k] = (old_pc + d * step) & mask;
            end else begin
                m_npc[k] = (m_npc[k] + step) & mask;
                m_ann[k] = annul;
            end
        end else if (cti == 2'd2) begin
            tgt = longint'(jmp) & mask;
            if (tgt % step != 0) m_mis[k] = 1'b1;
            else begin
                m_pc[k]  = m_npc[k];
                m_npc[k] = tgt;
            end
        end else begin
            m_pc[k]  = m_npc[k];
            m_npc[k] = (m_npc[k] + step) & mask;
        end
    endtask

    function automatic logic [127:0] exp_vec(input int k);
        longint mask;
        logic [31:0] p, n, p4;
        mask = (longint'(1) << mw[k]) - 1;
        p  = 32'(m_pc[k]);
        n  = 32'(m_npc[k]);
        p4 = 32'((m_pc[k] + (longint'(1) << mal[k])) & mask);
        return {29'b0, !m_boot[k], m_ann[k], m_mis[k], p, n, p4};
    endfunction

    function automatic logic [127:0] obs_a();
        return {29'b0, bus_a.fetch_valid_o, bus_a.annulled_o, bus_a.misalign_o,
                bus_a.pc_o, bus_a.npc_o, bus_a.pc4_o};
    endfunction

    function automatic logic [127:0] obs_b();
        return {29'b0, bus_b.fetch_valid_o, bus_b.annulled_o, bus_b.misalign_o,
                16'b0, bus_b.pc_o, 16'b0, bus_b.npc_o, 16'b0, bus_b.pc4_o};
    endfunction

    task automatic idle();
        stall = 0; cti = 2'd0; taken = 0; annul = 0; trap = 0;
        disp = '0; jmp = '0; tbr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic boot_to_0x10();
        idle(); rst = 1; tick();
        rst = 0; tick();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o, bus_a.fetch_valid_o, bus_a.annulled_o, bus_a.misalign_o} !== {32'h0, 32'h4, 3'b000}) begin
            errors++; $display("FAIL reset_a got pc=%h npc=%h fv=%b ann=%b mis=%b exp pc=0 npc=4 fv=0 ann=0 mis=0",
                bus_a.pc_o, bus_a.npc_o, bus_a.fetch_valid_o, bus_a.annulled_o, bus_a.misalign_o);
        end
        checks++;
        if ({bus_b.pc_o, bus_b.npc_o, bus_b.fetch_valid_o} !== {16'h0100, 16'h0102, 1'b0}) begin
            errors++; $display("FAIL reset_b got pc=%h npc=%h fv=%b exp pc=0100 npc=0102 fv=0",
                bus_b.pc_o, bus_b.npc_o, bus_b.fetch_valid_o);
        end
        rst = 0; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.fetch_valid_o} !== {32'h0, 1'b1}) begin
            errors++; $display("FAIL boot_exit got pc=%h fv=%b exp pc=0 fv=1", bus_a.pc_o, bus_a.fetch_valid_o);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({obs_a(), obs_b()} !== {exp_vec(0), exp_vec(1)}) begin
                errors++; $display("FAIL seq_model[%0d] got=%h exp=%h", i, {obs_a(), obs_b()}, {exp_vec(0), exp_vec(1)});
            end
        end
        checks++;
        if ({bus_a.pc_o, bus_a.pc4_o} !== {32'h28, 32'h2C}) begin
            errors++; $display("FAIL seq10 got pc=%h pc4=%h exp pc=28 pc4=2c", bus_a.pc_o, bus_a.pc4_o);
        end
    endtask

    task automatic test_branch();
        boot_to_0x10();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o} !== {32'h10, 32'h14}) begin
            errors++; $display("FAIL br_start got pc=%h npc=%h exp 10/14", bus_a.pc_o, bus_a.npc_o);
        end
        cti = 2'd1; taken = 1; disp = 32'hFFFF_FFFE; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o} !== {32'h14, 32'h08} || {obs_b()} !== exp_vec(1)) begin
            errors++; $display("FAIL br_taken got pc=%h npc=%h b=%h exp 14/08 b=%h", bus_a.pc_o, bus_a.npc_o, obs_b(), exp_vec(1));
        end
        idle(); tick();
        checks++;
        if (bus_a.pc_o !== 32'h08 || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL br_after got pc=%h b=%h exp pc=08 b=%h", bus_a.pc_o, obs_b(), exp_vec(1));
        end
    endtask

    task automatic test_annul();
        boot_to_0x10();
        cti = 2'd1; taken = 0; annul = 1; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.annulled_o, bus_a.fetch_valid_o} !== {32'h14, 1'b1, 1'b1} || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL annul_slot got pc=%h ann=%b fv=%b exp pc=14 ann=1 fv=1", bus_a.pc_o, bus_a.annulled_o, bus_a.fetch_valid_o);
        end
        // the squashed instruction's taken branch must be ignored
        cti = 2'd1; taken = 1; annul = 0; disp = 32'h0000_0100; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o, bus_a.annulled_o} !== {32'h18, 32'h1C, 1'b0} || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL annul_after got pc=%h npc=%h ann=%b exp pc=18 npc=1c ann=0", bus_a.pc_o, bus_a.npc_o, bus_a.annulled_o);
        end
        idle();
    endtask

    task automatic test_stall();
        boot_to_0x10();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus_a.pc_o, bus_a.npc_o, bus_a.misalign_o} !== {32'h10, 32'h14, 1'b0} || obs_b() !== exp_vec(1)) begin
                errors++; $display("FAIL stall[%0d] got pc=%h npc=%h mis=%b exp 10/14/0", i, bus_a.pc_o, bus_a.npc_o, bus_a.misalign_o);
            end
        end
        trap = 1; tbr = 32'h800; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o} !== {32'h800, 32'h804} || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL trap_in_stall got pc=%h npc=%h exp 800/804", bus_a.pc_o, bus_a.npc_o);
        end
        idle();
    endtask

    task automatic test_jump();
        boot_to_0x10();
        cti = 2'd2; jmp = 32'h102; tick();
        checks++;
        if ({bus_a.misalign_o, bus_a.pc_o, bus_a.npc_o} !== {1'b1, 32'h10, 32'h14} || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL jmp_mis got mis=%b pc=%h npc=%h exp 1/10/14", bus_a.misalign_o, bus_a.pc_o, bus_a.npc_o);
        end
        idle(); tick();
        checks++;
        if ({bus_a.misalign_o, bus_a.pc_o} !== {1'b0, 32'h14}) begin
            errors++; $display("FAIL jmp_mis_pulse got mis=%b pc=%h exp 0/14", bus_a.misalign_o, bus_a.pc_o);
        end
        cti = 2'd2; jmp = 32'hFFFF_FFFC; tick();
        idle(); tick();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o, bus_a.pc4_o} !== {32'hFFFF_FFFC, 32'h0, 32'h0} || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL wrap got pc=%h npc=%h pc4=%h exp fffffffc/0/0", bus_a.pc_o, bus_a.npc_o, bus_a.pc4_o);
        end
        trap = 1; tbr = 32'h801; tick();
        checks++;
        if ({bus_a.misalign_o, bus_a.pc_o} !== {1'b1, 32'hFFFF_FFFC} || obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL trap_mis got mis=%b pc=%h exp 1/fffffffc", bus_a.misalign_o, bus_a.pc_o);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        boot_to_0x10();
        cti = 2'd1; taken = 0; annul = 1; tick();
        idle(); rst = 1; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.annulled_o, bus_a.fetch_valid_o, bus_b.pc_o, bus_b.annulled_o} !== {32'h0, 1'b0, 1'b0, 16'h0100, 1'b0}) begin
            errors++; $display("FAIL rst_in_annul got a_pc=%h a_ann=%b a_fv=%b b_pc=%h b_ann=%b exp 0/0/0/0100/0",
                bus_a.pc_o, bus_a.annulled_o, bus_a.fetch_valid_o, bus_b.pc_o, bus_b.annulled_o);
        end
        boot_to_0x10();
        stall = 1; rst = 1; tick();
        checks++;
        if ({bus_a.pc_o, bus_a.npc_o, bus_b.pc_o, bus_b.npc_o} !== {32'h0, 32'h4, 16'h0100, 16'h0102}) begin
            errors++; $display("FAIL rst_in_stall got a=%h/%h b=%h/%h exp 0/4 0100/0102", bus_a.pc_o, bus_a.npc_o, bus_b.pc_o, bus_b.npc_o);
        end
        idle(); rst = 0;
    endtask

    task automatic test_random();
        idle(); rst = 1; tick();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            cti   = 2'($urandom);
            taken = 1'($urandom);
            annul = 1'($urandom);
            trap  = ($urandom_range(0, 9) == 0) && !m_ann[0] && !m_ann[1];
            disp  = $urandom;
            jmp   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tbr   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick();
            checks++;
            if ({obs_a(), obs_b()} !== {exp_vec(0), exp_vec(1)}) begin
                errors++; $display("FAIL random[%0d] got=%h exp=%h", i, {obs_a(), obs_b()}, {exp_vec(0), exp_vec(1)});
            end
        end
        idle(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_branch();
        test_annul();
        test_stall();
        test_jump();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
